// File: rtl/axi_mem_slave_if.sv
// AXI4 slave-side bus bundle (write address/data/response, read address/data)
// for the axi_mem_slave memory model.
interface axi_mem_slave_if;
    // Write address channel
    logic [3:0]  S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    // Write data channel
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    // Write response channel
    logic [3:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    // Read address channel
    logic [3:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    // Read data channel
    logic [3:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: queued AW/AR requests, word-addressed RAM with byte
// strobes, in-order B responses and INCR read bursts (4-byte beats).

// Simple count-based FIFO; caller guarantees no push when full, no pop when empty.
module axi_mem_slave_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             nempty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    // Entry storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o   = mem_q[rd_q];
    assign full_o   = (cnt_q == CNT_W'(DEPTH));
    assign nempty_o = (cnt_q != '0);
endmodule

module axi_mem_slave #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    axi_mem_slave_if.slave s_axi
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [3:0]  id;
        logic [29:0] waddr;
        logic [7:0]  len;
    } addr_req_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_ent_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LOAD = 2'd1,
        R_SEND = 2'd2
    } r_state_e;

    logic [31:0] mem_q [MEM_WORDS];

    // ---------------------------------------------------------------- queues
    addr_req_t aw_in_c, aw_head_c;
    logic      aw_push_c, aw_pop_c, aw_full_c, aw_nempty_c;
    b_ent_t    b_in_c, b_head_c;
    logic      b_push_c, b_pop_c, b_full_c, b_nempty_c;
    addr_req_t ar_in_c, ar_head_c;
    logic      ar_push_c, ar_pop_c, ar_full_c, ar_nempty_c;

    // Byte-offset bits are meaningless with fixed 4-byte beats.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign aw_in_c   = '{id: s_axi.S_AXI_AWID, waddr: s_axi.S_AXI_AWADDR[31:2],
                         len: s_axi.S_AXI_AWLEN};
    assign aw_push_c = s_axi.S_AXI_AWVALID && !aw_full_c;
    assign ar_in_c   = '{id: s_axi.S_AXI_ARID, waddr: s_axi.S_AXI_ARADDR[31:2],
                         len: s_axi.S_AXI_ARLEN};
    assign ar_push_c = s_axi.S_AXI_ARVALID && !ar_full_c;
    assign b_pop_c   = b_nempty_c && s_axi.S_AXI_BREADY;

    axi_mem_slave_fifo #(.WIDTH($bits(addr_req_t)), .DEPTH(QDEPTH)) u_aw_q (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .push_i   (aw_push_c),
        .data_i   (aw_in_c),
        .pop_i    (aw_pop_c),
        .data_o   (aw_head_c),
        .full_o   (aw_full_c),
        .nempty_o (aw_nempty_c)
    );

    axi_mem_slave_fifo #(.WIDTH($bits(b_ent_t)), .DEPTH(QDEPTH)) u_b_q (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .push_i   (b_push_c),
        .data_i   (b_in_c),
        .pop_i    (b_pop_c),
        .data_o   (b_head_c),
        .full_o   (b_full_c),
        .nempty_o (b_nempty_c)
    );

    axi_mem_slave_fifo #(.WIDTH($bits(addr_req_t)), .DEPTH(QDEPTH)) u_ar_q (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .push_i   (ar_push_c),
        .data_i   (ar_in_c),
        .pop_i    (ar_pop_c),
        .data_o   (ar_head_c),
        .full_o   (ar_full_c),
        .nempty_o (ar_nempty_c)
    );

    assign s_axi.S_AXI_AWREADY = !aw_full_c;
    assign s_axi.S_AXI_ARREADY = !ar_full_c;
    assign s_axi.S_AXI_BVALID  = b_nempty_c;
    assign s_axi.S_AXI_BID     = b_nempty_c ? b_head_c.id   : 4'd0;
    assign s_axi.S_AXI_BRESP   = b_nempty_c ? b_head_c.resp : RESP_OKAY;

    // ---------------------------------------------------------- write engine
    logic [7:0]  w_beat_q, w_beat_d;
    logic        w_err_q, w_err_d;
    logic        w_hs_c, w_last_c, w_oor_c, w_err_now_c;
    logic [29:0] w_idx_c;

    assign s_axi.S_AXI_WREADY = aw_nempty_c && !b_full_c;
    assign w_hs_c      = s_axi.S_AXI_WVALID && aw_nempty_c && !b_full_c;
    assign w_idx_c     = aw_head_c.waddr + 30'(w_beat_q);
    assign w_oor_c     = |w_idx_c[29:IDX_W];
    assign w_last_c    = (w_beat_q == aw_head_c.len);
    assign w_err_now_c = w_oor_c || (s_axi.S_AXI_WLAST != w_last_c);
    assign aw_pop_c    = w_hs_c && w_last_c;
    assign b_push_c    = aw_pop_c;
    assign b_in_c      = '{id: aw_head_c.id,
                           resp: (w_err_q || w_err_now_c) ? RESP_SLVERR : RESP_OKAY};

    // Beat counter and sticky burst error; the beat count, not WLAST, ends a burst.
    always_comb begin
        w_beat_d = w_beat_q;
        w_err_d  = w_err_q;
        if (w_hs_c) begin
            if (w_last_c) begin
                w_beat_d = 8'd0;
                w_err_d  = 1'b0;
            end else begin
                w_beat_d = w_beat_q + 8'd1;
                w_err_d  = w_err_q || w_err_now_c;
            end
        end
    end

    // Write-engine state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_beat_q <= 8'd0;
            w_err_q  <= 1'b0;
        end else begin
            w_beat_q <= w_beat_d;
            w_err_q  <= w_err_d;
        end
    end

    // RAM write with byte enables; out-of-range beats are dropped. RAM survives reset.
    always_ff @(posedge ACLK) begin
        if (w_hs_c && !w_oor_c) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem_q[w_idx_c[IDX_W-1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------- read engine
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [29:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_hs_c, r_oor_c;
    logic [7:0]  r_ld_beat_c;
    logic [29:0] r_idx_c;
    logic [31:0] r_word_c;

    // In SEND the next beat is fetched; in LOAD the current (first) one.
    assign r_hs_c      = rvalid_q && s_axi.S_AXI_RREADY;
    assign r_ld_beat_c = (r_state_q == R_SEND) ? (r_beat_q + 8'd1) : r_beat_q;
    assign r_idx_c     = r_addr_q + 30'(r_ld_beat_c);
    assign r_oor_c     = |r_idx_c[29:IDX_W];
    assign r_word_c    = mem_q[r_idx_c[IDX_W-1:0]];

    // Read FSM next-state and beat fetch.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_pop_c  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_nempty_c) begin
                    ar_pop_c  = 1'b1;
                    r_id_d    = ar_head_c.id;
                    r_addr_d  = ar_head_c.waddr;
                    r_len_d   = ar_head_c.len;
                    r_beat_d  = 8'd0;
                    r_state_d = R_LOAD;
                end
            end
            R_LOAD: begin
                rvalid_d  = 1'b1;
                rdata_d   = r_oor_c ? 32'd0 : r_word_c;
                rresp_d   = r_oor_c ? RESP_SLVERR : RESP_OKAY;
                rlast_d   = (r_ld_beat_c == r_len_q);
                r_state_d = R_SEND;
            end
            R_SEND: begin
                if (r_hs_c) begin
                    if (r_beat_q == r_len_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_ld_beat_c;
                        rdata_d  = r_oor_c ? 32'd0 : r_word_c;
                        rresp_d  = r_oor_c ? RESP_SLVERR : RESP_OKAY;
                        rlast_d  = (r_ld_beat_c == r_len_q);
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered R channel outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            r_id_q    <= 4'd0;
            r_addr_q  <= 30'd0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.S_AXI_RVALID = rvalid_q;
    assign s_axi.S_AXI_RLAST  = rlast_q;
    assign s_axi.S_AXI_RDATA  = rdata_q;
    assign s_axi.S_AXI_RRESP  = rresp_q;
    assign s_axi.S_AXI_RID    = r_id_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: write/read bursts, queue-full and
// B backpressure, byte strobes, error responses and reset mid-burst.
module tb_axi_mem_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    axi_mem_slave_if bus ();

    axi_mem_slave #(.MEM_WORDS(256), .QDEPTH(4)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .s_axi   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWVALID = 1'b1;
        while (!bus.S_AXI_AWREADY && n < 20) begin tick(); n++; end
        chk("aw_ready_wait", 32'(bus.S_AXI_AWREADY), 32'd1);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_WLAST  = last;
        bus.S_AXI_WVALID = 1'b1;
        while (!bus.S_AXI_WREADY && n < 20) begin tick(); n++; end
        chk("w_ready_wait", 32'(bus.S_AXI_WREADY), 32'd1);
        tick();
        bus.S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
        chk("ar_ready_wait", 32'(bus.S_AXI_ARREADY), 32'd1);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic expect_b(input logic [3:0] id, input logic [1:0] resp, input string tag);
        int n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin tick(); n++; end
        chk({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
        chk({tag, "_bid"},    32'(bus.S_AXI_BID),    32'(id));
        chk({tag, "_bresp"},  32'(bus.S_AXI_BRESP),  32'(resp));
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        int n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin tick(); n++; end
        chk({tag, "_rvalid"}, 32'(bus.S_AXI_RVALID), 32'd1);
    endtask

    task automatic expect_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                            input logic last, input string tag);
        wait_rvalid(tag);
        chk({tag, "_rid"},   32'(bus.S_AXI_RID),   32'(id));
        chk({tag, "_rdata"}, bus.S_AXI_RDATA,      data);
        chk({tag, "_rresp"}, 32'(bus.S_AXI_RRESP), 32'(resp));
        chk({tag, "_rlast"}, 32'(bus.S_AXI_RLAST), 32'(last));
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // Reset state
        #12;
        chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        chk("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
        chk("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
        chk("rst_bid",     32'(bus.S_AXI_BID),     32'd0);
        chk("rst_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
        chk("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
        chk("rst_rlast",   32'(bus.S_AXI_RLAST),   32'd0);
        chk("rst_rid",     32'(bus.S_AXI_RID),     32'd0);
        chk("rst_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
        chk("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Eight len-3 write bursts, then read them back
        for (int i = 0; i < 8; i++) begin
            send_aw(4'(i), 32'(16 * i), 8'd3);
            for (int k = 0; k < 4; k++)
                send_w(32'h1000_0000 + 32'(16 * i + k), 4'hF, (k == 3));
            expect_b(4'(i), 2'b00, "t1_b");
        end
        for (int i = 0; i < 7; i++) begin
            send_ar(4'(i), 32'(16 * i), 8'd3);
            if (i == 0) begin
                chk("t1_lat_n1", 32'(bus.S_AXI_RVALID), 32'd0);
                tick();
                chk("t1_lat_n2", 32'(bus.S_AXI_RVALID), 32'd0);
                tick();
                chk("t1_lat_n3", 32'(bus.S_AXI_RVALID), 32'd1);
            end
            if (i == 1) repeat (3) tick();
            for (int k = 0; k < 4; k++)
                expect_r(4'(i), 32'h1000_0000 + 32'(16 * i + k), 2'b00, (k == 3), "t1_r");
        end
        // Last burst streamed with RREADY held high
        send_ar(4'd7, 32'h70, 8'd3);
        wait_rvalid("t1_s_first");
        bus.S_AXI_RREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1_s_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
            chk("t1_s_rdata",  bus.S_AXI_RDATA, 32'h1000_0070 + 32'(k));
            chk("t1_s_rlast",  32'(bus.S_AXI_RLAST), 32'(k == 3));
            tick();
        end
        bus.S_AXI_RREADY = 1'b0;
        chk("t1_s_done", 32'(bus.S_AXI_RVALID), 32'd0);

        // AW queue full
        for (int j = 0; j < 4; j++) send_aw(4'(j + 1), 32'h80 + 32'(4 * j), 8'd0);
        chk("t2_awready_full", 32'(bus.S_AXI_AWREADY), 32'd0);
        bus.S_AXI_AWID = 4'd5; bus.S_AXI_AWADDR = 32'h90; bus.S_AXI_AWLEN = 8'd0;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        chk("t2_awready_still", 32'(bus.S_AXI_AWREADY), 32'd0);
        send_w(32'hA000_0001, 4'hF, 1'b1);
        chk("t2_awready_back", 32'(bus.S_AXI_AWREADY), 32'd1);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        chk("t2_awready_refull", 32'(bus.S_AXI_AWREADY), 32'd0);
        expect_b(4'd1, 2'b00, "t2_b");
        for (int j = 1; j < 5; j++) begin
            send_w(32'hA000_0001 + 32'(j), 4'hF, 1'b1);
            expect_b(4'(j + 1), 2'b00, "t2_b");
        end

        // B backpressure
        for (int j = 0; j < 4; j++) begin
            send_aw(4'(6 + j), 32'hA0 + 32'(4 * j), 8'd0);
            send_w(32'hB000_0000 + 32'(j), 4'hF, 1'b1);
        end
        chk("t3_bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
        send_aw(4'd10, 32'hB0, 8'd0);
        chk("t3_wready_blocked", 32'(bus.S_AXI_WREADY), 32'd0);
        bus.S_AXI_WDATA = 32'hB000_0004; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        repeat (3) tick();
        chk("t3_wready_still", 32'(bus.S_AXI_WREADY), 32'd0);
        bus.S_AXI_WVALID = 1'b0;
        for (int j = 0; j < 4; j++) expect_b(4'(6 + j), 2'b00, "t3_b");
        send_w(32'hB000_0004, 4'hF, 1'b1);
        expect_b(4'd10, 2'b00, "t3_b5");

        // Byte strobes
        send_aw(4'd1, 32'h0, 8'd0);
        send_w(32'hFFFF_FFFF, 4'hF, 1'b1);
        expect_b(4'd1, 2'b00, "t4_b_full");
        send_aw(4'd2, 32'h0, 8'd0);
        send_w(32'h1234_5678, 4'b0011, 1'b1);
        expect_b(4'd2, 2'b00, "t4_b_strb");
        send_ar(4'd3, 32'h0, 8'd0);
        expect_r(4'd3, 32'hFFFF_5678, 2'b00, 1'b1, "t4_r");

        // Out-of-range write: SLVERR, word 0 must not be aliased
        send_aw(4'd4, 32'h400, 8'd0);
        send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        expect_b(4'd4, 2'b10, "t5_oor_b");
        send_ar(4'd5, 32'h0, 8'd0);
        expect_r(4'd5, 32'hFFFF_5678, 2'b00, 1'b1, "t5_alias_r");

        // Early WLAST: still four beats, SLVERR, data written
        send_aw(4'd6, 32'h100, 8'd3);
        send_w(32'hC000_0000, 4'hF, 1'b0);
        send_w(32'hC000_0001, 4'hF, 1'b1);
        chk("t5_no_early_b1", 32'(bus.S_AXI_BVALID), 32'd0);
        send_w(32'hC000_0002, 4'hF, 1'b0);
        chk("t5_no_early_b2", 32'(bus.S_AXI_BVALID), 32'd0);
        send_w(32'hC000_0003, 4'hF, 1'b1);
        expect_b(4'd6, 2'b10, "t5_wlast_b");
        send_ar(4'd7, 32'h100, 8'd3);
        for (int k = 0; k < 4; k++)
            expect_r(4'd7, 32'hC000_0000 + 32'(k), 2'b00, (k == 3), "t5_wlast_r");

        // Burst straddling the top of memory
        send_aw(4'd8, 32'h3FC, 8'd1);
        send_w(32'h5555_AAAA, 4'hF, 1'b0);
        send_w(32'h6666_BBBB, 4'hF, 1'b1);
        expect_b(4'd8, 2'b10, "t5_edge_b");
        send_ar(4'd9, 32'h3FC, 8'd1);
        expect_r(4'd9, 32'h5555_AAAA, 2'b00, 1'b0, "t5_edge_r0");
        expect_r(4'd9, 32'h0,         2'b10, 1'b1, "t5_edge_r1");
        send_ar(4'd11, 32'h400, 8'd0);
        expect_r(4'd11, 32'h0, 2'b10, 1'b1, "t5_oor_r");

        // Reset during beat 2 of a read burst, with another AR queued
        send_ar(4'd10, 32'h0, 8'd3);
        expect_r(4'd10, 32'hFFFF_5678, 2'b00, 1'b0, "t6_r0");
        expect_r(4'd10, 32'h1000_0001, 2'b00, 1'b0, "t6_r1");
        send_ar(4'd12, 32'h10, 8'd0);
        wait_rvalid("t6_beat2");
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
        chk("t6_rlast",   32'(bus.S_AXI_RLAST),   32'd0);
        chk("t6_rdata",   bus.S_AXI_RDATA,        32'd0);
        chk("t6_rid",     32'(bus.S_AXI_RID),     32'd0);
        chk("t6_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("t6_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        chk("t6_wready",  32'(bus.S_AXI_WREADY),  32'd0);
        chk("t6_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_no_stale_r", 32'(bus.S_AXI_RVALID), 32'd0);
        end
        send_ar(4'd13, 32'h0, 8'd0);
        expect_r(4'd13, 32'hFFFF_5678, 2'b00, 1'b1, "t6_kept0");
        send_ar(4'd14, 32'h10, 8'd0);
        expect_r(4'd14, 32'h1000_0010, 2'b00, 1'b1, "t6_kept4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
